// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide unit.
// One radix-2 step per cycle: shift-add for products, restoring
// shift-subtract for quotients. Operands are converted to magnitudes on
// entry and the final sign is applied when the result is captured.
//
//   state | meaning
//   IDLE  | waiting for start; divide exceptions resolve here in one cycle
//   CALC  | 32 iteration cycles, counter 0..31
//   DONE  | one-cycle done pulse, Result valid, pipeline released
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [2:0]         op_r;
  logic               sa_r, sb_r;
  logic [WIDTH-1:0]   div_r, q_r, q_nx;
  logic [2*WIDTH-1:0] acc_r, acc_nx, mcand_r, prod;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   quo, rem, calc_res;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, exc_res;
  logic             accept, div_zero, ovf, exc, last;

  // operand decode: signedness per op, magnitudes and divide exceptions
  assign a_signed = ~funct3[0] | (funct3 == 3'b001);
  assign b_signed = (~funct3[2] & ~funct3[1]) | (funct3[2] & ~funct3[0]);
  assign a_neg    = a_signed & SrcA[WIDTH-1];
  assign b_neg    = b_signed & SrcB[WIDTH-1];
  assign mag_a    = a_neg ? -SrcA : SrcA;
  assign mag_b    = b_neg ? -SrcB : SrcB;
  assign div_zero = funct3[2] & (SrcB == '0);
  assign ovf      = funct3[2] & ~funct3[0] & (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcB == '1);
  assign exc      = div_zero | ovf;
  // on overflow DIV returns the dividend itself (0x80000000)
  assign exc_res  = div_zero ? (funct3[1] ? SrcA : '1) : (funct3[1] ? '0 : SrcA);
  assign accept   = (state == IDLE) & start & ~flush;
  assign last     = (state == CALC) & (cnt == CW'(WIDTH - 1));

  // one iteration step of the latched op
  always_comb begin
    rem_sh = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
    ge     = rem_sh >= {1'b0, div_r};
    if (op_r[2]) begin
      acc_nx = {{(WIDTH-1){1'b0}}, ge ? rem_sh - {1'b0, div_r} : rem_sh};
      q_nx   = {q_r[WIDTH-2:0], ge};
    end else begin
      acc_nx = q_r[0] ? acc_r + mcand_r : acc_r;
      q_nx   = {1'b0, q_r[WIDTH-1:1]};
    end
  end

  // sign fix-up and result selection from the final iteration
  always_comb begin
    prod = (sa_r ^ sb_r) ? -acc_nx : acc_nx;
    quo  = (sa_r ^ sb_r) ? -q_nx : q_nx;
    rem  = sa_r ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
    case (op_r)
      3'b000:                 calc_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         calc_res = quo;
      default:                calc_res = rem;
    endcase
  end

  // datapath registers; contents are only observed through Result
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r    <= funct3;
      sa_r    <= a_neg;
      sb_r    <= b_neg;
      acc_r   <= '0;
      div_r   <= mag_b;
      mcand_r <= {{WIDTH{1'b0}}, mag_a};
      q_r     <= funct3[2] ? mag_a : mag_b;
    end else if (state == CALC) begin
      acc_r   <= acc_nx;
      q_r     <= q_nx;
      mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
    end
  end

  // state, iteration counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      Result <= '0;
    end else begin
      state <= state_nx;
      if (flush || state != CALC) cnt <= '0;
      else                        cnt <= cnt + 1'b1;
      if (accept && exc)        Result <= exc_res;
      else if (last && !flush)  Result <= calc_res;
    end
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nx = exc ? DONE : CALC;
        CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // status outputs; stall drops in DONE so the pipeline captures Result
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    stall = ((state == IDLE) & start) | (state == CALC);
  end

endmodule
